// File: rtl/masked_pkg.sv
// masked_pkg: shared FSM states, share-pair type and operand-count limits
// for the masked AND chain sequencer.
package masked_pkg;
    typedef enum logic [1:0] {IDLE, MUL, COMB, DONE} state_t;
    typedef struct packed {
        logic s0;
        logic s1;
    } share_t;
    localparam int N_IN_MIN = 2;
    localparam int N_IN_MAX = 16;
endpackage

// File: rtl/dom_and_stage.sv
// dom_and_stage: one registered first-order DOM AND; cross terms are
// re-masked with r and registered before compression to block glitch leakage.
module dom_and_stage
    import masked_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  share_t a,
    input  share_t b,
    input  logic   r,
    output logic   t00,
    output logic   t01,
    output logic   t10,
    output logic   t11,
    output share_t c
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {t00, t01, t10, t11} <= '0;
        end else if (en) begin
            t00 <= a.s0 & b.s0;
            t01 <= (a.s0 & b.s1) ^ r;
            t10 <= (a.s1 & b.s0) ^ r;
            t11 <= a.s1 & b.s1;
        end
    end
    assign c = '{s0: t00 ^ t01, s1: t11 ^ t10};
endmodule

// File: rtl/masked_and_chain_seq.sv
// masked_and_chain_seq: ANDs N_IN 2-share masked bits by folding them one at a
// time through a single DOM AND stage, one fresh random bit per step.
module masked_and_chain_seq
    import masked_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] x0,
    input  logic [N_IN-1:0] x1,
    input  logic            rnd,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    output logic            out0,
    output logic            out1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);
    localparam int CNT_W = $clog2(N_IN);

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
        $error("masked_and_chain_seq: N_IN out of range");
    end

    state_t          state;
    logic [N_IN-1:0] xr0, xr1;
    share_t          acc, b, c;
    logic [CNT_W-1:0] cnt;
    logic [3:0]      unused_terms;

    assign b         = '{s0: xr0[cnt], s1: xr1[cnt]};
    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign rnd_ready = state == MUL && rnd_valid;
    assign out_valid = state == DONE;
    assign out0      = acc.s0;
    assign out1      = acc.s1;

    dom_and_stage u_dom (
        .clk (clk),
        .rst (rst),
        .en  (rnd_ready),
        .a   (acc),
        .b   (b),
        .r   (rnd),
        .t00 (unused_terms[3]),
        .t01 (unused_terms[2]),
        .t10 (unused_terms[1]),
        .t11 (unused_terms[0]),
        .c   (c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            xr0   <= '0;
            xr1   <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    xr0   <= x0;
                    xr1   <= x1;
                    acc   <= '{s0: x0[0], s1: x1[0]};
                    cnt   <= CNT_W'(1);
                    state <= MUL;
                end
                MUL: if (rnd_valid) state <= COMB;
                COMB: begin
                    acc <= c;
                    if (cnt == CNT_W'(N_IN - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        state <= MUL;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_masked_and_chain_seq.sv
// tb_masked_and_chain_seq: random and directed checks of the masked AND
// sequencer against a transaction-level model of its handshakes and result.
module tb_masked_and_chain_seq;
    localparam int N = 3;

    logic clk = 0, rst = 1;
    logic in_valid = 0, rnd = 0, rnd_valid = 0, out_ready = 1;
    logic [N-1:0] x0 = '0, x1 = '0;
    logic in_ready, rnd_ready, out0, out1, out_valid, busy;

    logic in_valid2 = 0, rnd2 = 0, rnd_valid2 = 0, out_ready2 = 1;
    logic [1:0] x0_2 = '0, x1_2 = '0;
    logic in_ready2, rnd_ready2, out0_2, out1_2, out_valid2, busy2;

    masked_and_chain_seq #(.N_IN(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .out0(out0), .out1(out1), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    masked_and_chain_seq #(.N_IN(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .x0(x0_2), .x1(x1_2), .rnd(rnd2), .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2),
        .out0(out0_2), .out1(out1_2), .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int nchk = 0, nfail = 0, cyc = 0, rr_cnt = 0, stall_n = 0;
    bit gaps = 0, rfix = 0;
    logic [1:0] seen [8] = '{default: '0};

    always @(posedge clk) cyc++;
    always @(negedge clk) if (rnd_ready) rr_cnt++;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of folding the operands left to right, one random bit per product.
    function automatic logic [1:0] chain(input logic [N-1:0] a0, input logic [N-1:0] a1, input logic [15:0] r);
        logic p0, p1, n0;
        p0 = a0[0];
        p1 = a1[0];
        for (int i = 1; i < N; i++) begin
            n0 = (p0 & a0[i]) ^ (p0 & a1[i]) ^ r[i-1];
            p1 = (p1 & a1[i]) ^ (p1 & a0[i]) ^ r[i-1];
            p0 = n0;
        end
        return {p0, p1};
    endfunction

    // Randomness source: optional forced value, start-of-op stall, random gaps.
    always @(posedge clk) begin
        #1;
        rnd = rfix ? 1'b1 : 1'($urandom);
        if (stall_n > 0) begin
            rnd_valid = 0;
            stall_n--;
        end else begin
            rnd_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Transaction timeline: wait for a random bit, spend one cycle combining.
    typedef enum {P_IDLE, P_MUL, P_COMB, P_DONE} ph_t;
    ph_t ph = P_IDLE;
    logic [N-1:0] mx0 = '0, mx1 = '0;
    logic [15:0] rq = '0;
    int nr = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = P_IDLE;
            nr = 0;
        end else begin
            case (ph)
                P_IDLE: if (in_valid) begin mx0 = x0; mx1 = x1; nr = 0; ph = P_MUL; end
                P_MUL:  if (rnd_valid) begin rq[nr] = rnd; nr++; ph = P_COMB; end
                P_COMB: ph = (nr == N - 1) ? P_DONE : P_MUL;
                P_DONE: if (out_ready) ph = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", 8'({out0, out1, out_valid, rnd_ready, busy, in_ready}), 8'b0000_0001);
        end else begin
            chk("busy", 8'(busy), 8'(ph != P_IDLE));
            chk("in_ready", 8'(in_ready), 8'(ph == P_IDLE));
            chk("out_valid", 8'(out_valid), 8'(ph == P_DONE));
            chk("rnd_ready", 8'(rnd_ready), 8'(ph == P_MUL && rnd_valid));
            if (ph == P_DONE) begin
                chk("result_shares", 8'({out0, out1}), 8'(chain(mx0, mx1, rq)));
                seen[mx0 ^ mx1][out1] = 1'b1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [N-1:0] a0, input logic [N-1:0] a1, input int st, output int hs);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("start_timeout", 8'(w < 50), 8'd1);
        in_valid = 1;
        x0 = a0;
        x1 = a1;
        stall_n = st;
        tick();
        hs = cyc;
        in_valid = 0;
        x0 = N'($urandom);
        x1 = N'($urandom);
    endtask

    task automatic wait_ov(input int hs, output int lat);
        while (!out_valid && cyc - hs < 100) tick();
        lat = cyc - hs;
        chk("out_valid_timeout", 8'(out_valid), 8'd1);
    endtask

    initial begin
        int hs, lat, base, l2, c2;
        logic [1:0] a, o;
        logic [N-1:0] s, v, ra0, ra1;
        logic r2;
        chk("model_pin_basic", 8'(chain(3'b101, 3'b010, 16'hffff)), 8'(2'b10));
        chk("model_pin_ones", 8'(chain(3'b111, 3'b000, 16'h0000)), 8'(2'b10));
        chk("model_pin_zero", 8'(chain(3'b011, 3'b000, 16'h0001)), 8'(2'b00));
        repeat (3) tick();
        rst = 0;
        tick();

        // Basic: rnd forced to 1
        rfix = 1;
        base = rr_cnt;
        start(3'b101, 3'b010, 0, hs);
        repeat (3) @(negedge clk);
        a = dut.acc;
        chk("acc_after_step1", 8'(a), 8'(2'b01));
        wait_ov(hs, lat);
        chk("basic_latency", 8'(lat), 8'd4);
        chk("basic_out", 8'({out0, out1}), 8'(2'b10));
        chk("basic_rnd_count", 8'(rr_cnt - base), 8'd2);
        tick();
        @(negedge clk);
        chk("basic_busy_low", 8'(busy), 8'd0);
        rfix = 0;

        // rnd stall on the first step
        ra0 = N'($urandom);
        ra1 = N'($urandom);
        start(ra0, ra1, 3, hs);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rnd_ready", 8'(rnd_ready), 8'd0);
            a = dut.acc;
            chk("stall_acc_held", 8'(a), 8'({ra0[0], ra1[0]}));
        end
        wait_ov(hs, lat);
        chk("stall_latency", 8'(lat), 8'd7);
        tick();

        // Backpressure in DONE while a new operand vector is offered
        out_ready = 0;
        start(N'($urandom), N'($urandom), 0, hs);
        wait_ov(hs, lat);
        chk("bp_latency", 8'(lat), 8'd4);
        o = {out0, out1};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            x0 = N'($urandom);
            x1 = N'($urandom);
            tick();
            chk("bp_out_valid", 8'(out_valid), 8'd1);
            chk("bp_out_stable", 8'({out0, out1}), 8'(o));
            chk("bp_in_ready", 8'(in_ready), 8'd0);
        end
        out_ready = 1;
        tick();
        chk("bp_release_in_ready", 8'(in_ready), 8'd1);
        chk("bp_release_out_valid", 8'(out_valid), 8'd0);
        tick();
        hs = cyc;
        in_valid = 0;
        chk("bp_next_accepted", 8'(busy), 8'd1);
        wait_ov(hs, lat);
        chk("bp_next_latency", 8'(lat), 8'd4);
        tick();

        // Reset during the COMB of step 1
        start(N'($urandom), N'($urandom), 0, hs);
        tick();
        #2;
        rst = 1;
        #1;
        chk("async_reset_outputs", 8'({out0, out1, out_valid, rnd_ready, busy, in_ready}), 8'b0000_0001);
        base = rr_cnt;
        repeat (2) tick();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_reset_no_valid", 8'(out_valid), 8'd0);
        end
        chk("post_reset_no_rnd", 8'(rr_cnt - base), 8'd0);
        start(3'b111, 3'b000, 0, hs);
        wait_ov(hs, lat);
        chk("post_reset_result", 8'(out0 ^ out1), 8'd1);
        tick();

        // All unmasked values, random share splits and randomness gaps
        gaps = 1;
        for (int vi = 0; vi < 8; vi++) begin
            v = N'(vi);
            for (int k = 0; k < 16; k++) begin
                s = N'($urandom);
                base = rr_cnt;
                start(s, s ^ v, 0, hs);
                wait_ov(hs, lat);
                chk("exh_and", 8'(out0 ^ out1), 8'(&v));
                chk("exh_rnd_count", 8'(rr_cnt - base), 8'(N - 1));
                tick();
            end
            chk("share_independence", 8'(seen[vi]), 8'(2'b11));
        end
        gaps = 0;

        // Two-operand build
        r2 = 1'($urandom);
        @(negedge clk);
        x0_2 = 2'b11;
        x1_2 = 2'b00;
        rnd2 = r2;
        rnd_valid2 = 1;
        in_valid2 = 1;
        tick();
        in_valid2 = 0;
        l2 = 0;
        c2 = 0;
        forever begin
            @(negedge clk);
            if (rnd_ready2) c2++;
            if (out_valid2 || l2 >= 50) break;
            tick();
            l2++;
        end
        chk("n2_latency", 8'(l2), 8'd2);
        chk("n2_rnd_count", 8'(c2), 8'd1);
        chk("n2_out", 8'({out0_2, out1_2}), 8'({~r2, r2}));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", nfail);
        $fatal(1);
    end
endmodule
